// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter that shares one single-port memory controller between two requesters.
// It latches one command per grant, issues it, waits for the read data and routes it back.
module mem_req_arbiter #(
    parameter int R = 4,
    parameter int C = 4,
    parameter int N = 4,
    parameter int TIMEOUT = 16,
    localparam int AW = $clog2(R * C)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_rw,
    input  logic [AW-1:0] p0_addr,
    input  logic [N-1:0]  p0_wdata,
    output logic          p0_ack,
    output logic [N-1:0]  p0_rdata,
    output logic          p0_rvalid,
    input  logic          p1_req,
    input  logic          p1_rw,
    input  logic [AW-1:0] p1_addr,
    input  logic [N-1:0]  p1_wdata,
    output logic          p1_ack,
    output logic [N-1:0]  p1_rdata,
    output logic          p1_rvalid,
    output logic          m_cs,
    output logic          m_req,
    output logic          m_rw,
    output logic [AW-1:0] m_addr,
    output logic [N-1:0]  m_qi,
    input  logic [N-1:0]  m_qa,
    input  logic          m_valid,
    input  logic          m_ready,
    output logic          rd_timeout
);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RDWAIT = 2'd2} state_t;

    state_t          state;
    logic            rr_ptr;
    logic            owner;
    logic            cmd_rw;
    logic [AW-1:0]   cmd_addr;
    logic [N-1:0]    cmd_wdata;
    logic [TW-1:0]   timer;
    logic            any_req;
    logic            gnt_port;

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        any_req  = p0_req | p1_req;
        gnt_port = (p0_req && p1_req) ? ~rr_ptr : p1_req;
    end

    // Handshake: a command is transferred on a cycle where m_req and m_ready are both high;
    // the owning port sees its ack in that same cycle and may drop or change its request at the edge.
    assign p0_ack = (state == ISSUE) && m_ready && !owner;
    assign p1_ack = (state == ISSUE) && m_ready && owner;

    assign m_rw   = cmd_rw;
    assign m_addr = cmd_addr;
    assign m_qi   = cmd_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= 1'b1;
            owner      <= 1'b0;
            cmd_rw     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            timer      <= '0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
            p0_rvalid  <= 1'b0;
            p1_rvalid  <= 1'b0;
            rd_timeout <= 1'b0;
            m_cs       <= 1'b0;
            m_req      <= 1'b0;
        end else begin
            p0_rvalid  <= 1'b0;
            p1_rvalid  <= 1'b0;
            rd_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state     <= ISSUE;
                        owner     <= gnt_port;
                        rr_ptr    <= gnt_port;
                        cmd_rw    <= gnt_port ? p1_rw : p0_rw;
                        cmd_addr  <= gnt_port ? p1_addr : p0_addr;
                        cmd_wdata <= gnt_port ? p1_wdata : p0_wdata;
                        m_cs      <= 1'b1;
                        m_req     <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (m_ready) begin
                        m_req <= 1'b0;
                        if (cmd_rw) begin
                            state <= RDWAIT;
                            timer <= '0;
                        end else begin
                            state <= IDLE;
                            m_cs  <= 1'b0;
                        end
                    end
                end
                RDWAIT: begin
                    // Data arriving on the terminal count still wins over the abort.
                    if (m_valid) begin
                        if (owner) begin
                            p1_rdata  <= m_qa;
                            p1_rvalid <= 1'b1;
                        end else begin
                            p0_rdata  <= m_qa;
                            p0_rvalid <= 1'b1;
                        end
                        state <= IDLE;
                        m_cs  <= 1'b0;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        rd_timeout <= 1'b1;
                        state      <= IDLE;
                        m_cs       <= 1'b0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    m_cs  <= 1'b0;
                    m_req <= 1'b0;
                end
            endcase
        end
    end
endmodule
